// File: rtl/ruler_search_sequencer_if.sv
// Bus between the search sequencer and the chain of mark counters: the
// counters report their state upward and the sequencer broadcasts its controls down.
interface ruler_search_sequencer_if #(
   parameter int NPOS = 5,
   parameter int VW   = 6,
   parameter int MAXV = 63,
   parameter int EW   = 3
);
   logic [NPOS-1:0]      cnt_ready;
   logic [NPOS*EW-1:0]   cnt_next_enabled;
   logic [NPOS*VW-1:0]   cnt_next_start;
   logic [NPOS*VW-1:0]   cnt_val;
   logic [NPOS*MAXV-1:0] cnt_pd_hash;
   logic [EW-1:0]        enabled;
   logic                 global_ready;
   logic [VW-1:0]        start_value;
   logic [VW-1:0]        limit;
   logic [MAXV-1:0]      distances;

   modport master (
      input  cnt_ready, cnt_next_enabled, cnt_next_start, cnt_val, cnt_pd_hash,
      output enabled, global_ready, start_value, limit, distances
   );

   modport slave (
      output cnt_ready, cnt_next_enabled, cnt_next_start, cnt_val, cnt_pd_hash,
      input  enabled, global_ready, start_value, limit, distances
   );
endinterface

// File: rtl/ruler_search_sequencer.sv
// Golomb ruler search controller: passes the level token along the counter chain,
// merges distance hashes, records completed rulers and tightens the length bound.
module ruler_search_sequencer #(
   parameter int NPOS    = 5,
   parameter int VW      = 6,
   parameter int MAXV    = 63,
   parameter int EW      = 3,
   parameter int TIMEOUT = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     start,
   input  logic [VW-1:0]            init_limit,
   ruler_search_sequencer_if.master bus,
   output logic                     sol_valid,
   output logic [NPOS*VW-1:0]       sol_marks,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [31:0]              steps
);
   localparam int WW = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_EVAL  = 3'd3;
   localparam logic [2:0] S_FIN   = 3'd4;

   localparam logic [EW-1:0] LVL_NONE  = {EW{1'b0}};
   localparam logic [EW-1:0] LVL_ONE   = EW'(1);
   localparam logic [EW-1:0] LVL_FULL  = EW'(NPOS + 1);
   localparam logic [WW-1:0] WAIT_ZERO = {WW{1'b0}};
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
   localparam logic [31:0]   STEPS_MAX = 32'hFFFF_FFFF;

   logic [2:0]         state_q, state_d;
   logic [WW-1:0]      wcnt_q, wcnt_d;
   logic [EW-1:0]      enabled_q, enabled_d;
   logic               global_ready_q, global_ready_d;
   logic [VW-1:0]      start_value_q, start_value_d;
   logic [VW-1:0]      limit_q, limit_d;
   logic [MAXV-1:0]    distances_q, distances_d;
   logic               sol_valid_q, sol_valid_d;
   logic [NPOS*VW-1:0] sol_marks_q, sol_marks_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [31:0]        steps_q, steps_d;

   logic               act_ready_s;
   logic [EW-1:0]      act_next_s;
   logic [VW-1:0]      act_start_s;
   logic [MAXV-1:0]    dist_s;
   logic               hit_s;

   // Select the active level's response and fold the hashes of the levels below its successor.
   always_comb begin
      act_ready_s = 1'b0;
      act_next_s  = {EW{1'b0}};
      act_start_s = {VW{1'b0}};
      dist_s      = {MAXV{1'b0}};
      hit_s       = 1'b0;
      for (int l = 0; l < NPOS; l++) begin
         hit_s       = (enabled_q == EW'(l + 1));
         act_ready_s = act_ready_s | (hit_s & bus.cnt_ready[l]);
         act_next_s  = act_next_s  | ({EW{hit_s}} & bus.cnt_next_enabled[l*EW +: EW]);
         act_start_s = act_start_s | ({VW{hit_s}} & bus.cnt_next_start[l*VW +: VW]);
      end
      for (int l = 0; l < NPOS; l++) begin
         dist_s = dist_s | ({MAXV{EW'(l + 1) < act_next_s}} & bus.cnt_pd_hash[l*MAXV +: MAXV]);
      end
   end

   // Round sequencing; every output is registered from the values chosen here.
   always_comb begin
      state_d        = state_q;
      wcnt_d         = wcnt_q;
      enabled_d      = enabled_q;
      global_ready_d = 1'b0;
      start_value_d  = start_value_q;
      limit_d        = limit_q;
      distances_d    = distances_q;
      sol_valid_d    = 1'b0;
      sol_marks_d    = sol_marks_q;
      busy_d         = busy_q;
      done_d         = done_q;
      error_d        = error_q;
      steps_d        = steps_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d        = S_ISSUE;
               global_ready_d = 1'b1;
               limit_d        = init_limit;
               enabled_d      = LVL_ONE;
               start_value_d  = VW'(1);
               distances_d    = {MAXV{1'b0}};
               steps_d        = 32'd0;
               done_d         = 1'b0;
               error_d        = 1'b0;
               busy_d         = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
            wcnt_d  = WAIT_ZERO;
            if (steps_q != STEPS_MAX) begin
               steps_d = steps_q + 32'd1;
            end else begin
               steps_d = steps_q;
            end
         end
         S_WAIT: begin
            // A counter-progress test would always be met by the two-cycle floor,
            // so only the floor and the active level's ready gate evaluation.
            if ((wcnt_q != WAIT_ZERO) && act_ready_s) begin
               state_d = S_EVAL;
            end else if (wcnt_q == WAIT_LAST) begin
               state_d   = S_FIN;
               error_d   = 1'b1;
               enabled_d = LVL_NONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else begin
               wcnt_d = wcnt_q + WW'(1);
            end
         end
         S_EVAL: begin
            if (act_next_s == LVL_NONE) begin
               state_d   = S_FIN;
               enabled_d = LVL_NONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end else if (act_next_s == LVL_FULL) begin
               state_d        = S_ISSUE;
               global_ready_d = 1'b1;
               sol_valid_d    = 1'b1;
               sol_marks_d    = bus.cnt_val;
               limit_d        = bus.cnt_val[NPOS*VW-1 -: VW];
            end else if (act_next_s < LVL_FULL) begin
               state_d        = S_ISSUE;
               global_ready_d = 1'b1;
               enabled_d      = act_next_s;
               start_value_d  = act_start_s;
               distances_d    = dist_s;
            end else begin
               state_d   = S_FIN;
               error_d   = 1'b1;
               enabled_d = LVL_NONE;
               busy_d    = 1'b0;
               done_d    = 1'b1;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d   = S_IDLE;
            enabled_d = LVL_NONE;
            busy_d    = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         wcnt_q         <= WAIT_ZERO;
         enabled_q      <= LVL_NONE;
         global_ready_q <= 1'b0;
         start_value_q  <= {VW{1'b0}};
         limit_q        <= {VW{1'b0}};
         distances_q    <= {MAXV{1'b0}};
         sol_valid_q    <= 1'b0;
         sol_marks_q    <= {(NPOS*VW){1'b0}};
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         steps_q        <= 32'd0;
      end else begin
         state_q        <= state_d;
         wcnt_q         <= wcnt_d;
         enabled_q      <= enabled_d;
         global_ready_q <= global_ready_d;
         start_value_q  <= start_value_d;
         limit_q        <= limit_d;
         distances_q    <= distances_d;
         sol_valid_q    <= sol_valid_d;
         sol_marks_q    <= sol_marks_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         error_q        <= error_d;
         steps_q        <= steps_d;
      end
   end

   assign bus.enabled      = enabled_q;
   assign bus.global_ready = global_ready_q;
   assign bus.start_value  = start_value_q;
   assign bus.limit        = limit_q;
   assign bus.distances    = distances_q;
   assign sol_valid        = sol_valid_q;
   assign sol_marks        = sol_marks_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign error            = error_q;
   assign steps            = steps_q;

endmodule

// File: tb/tb_ruler_search_sequencer.sv
// Bench for ruler_search_sequencer: scripted and random counter responses,
// each round checked against a round-level model of the sequencer.
module tb_ruler_search_sequencer;
   localparam int NPOS    = 5;
   localparam int VW      = 6;
   localparam int MAXV    = 63;
   localparam int EW      = 3;
   localparam int TIMEOUT = 64;

   logic               clock = 1'b0;
   logic               reset;
   logic               start;
   logic [VW-1:0]      init_limit;
   logic               sol_valid;
   logic [NPOS*VW-1:0] sol_marks;
   logic               busy;
   logic               done;
   logic               error;
   logic [31:0]        steps;

   ruler_search_sequencer_if #(.NPOS(NPOS), .VW(VW), .MAXV(MAXV), .EW(EW)) bus ();

   ruler_search_sequencer #(
      .NPOS(NPOS), .VW(VW), .MAXV(MAXV), .EW(EW), .TIMEOUT(TIMEOUT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .start      (start),
      .init_limit (init_limit),
      .bus        (bus),
      .sol_valid  (sol_valid),
      .sol_marks  (sol_marks),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .steps      (steps)
   );

   always #5 clock = ~clock;

   int n_cmp  = 0;
   int n_fail = 0;

   // round-level model of what the sequencer should be showing
   int              m_enabled;
   int              m_issues;
   logic [VW-1:0]   m_start_value;
   logic [VW-1:0]   m_limit;
   logic [MAXV-1:0] m_distances;
   logic [VW-1:0]   fixed_vals [1:NPOS];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start_search(input logic [VW-1:0] lim);
      @(negedge clock);
      start      = 1'b1;
      init_limit = lim;
      bus.cnt_ready = '0;
      @(negedge clock);
      start      = 1'b0;
      init_limit = VW'($urandom);
      m_enabled     = 1;
      m_start_value = VW'(1);
      m_limit       = lim;
      m_distances   = '0;
      m_issues      = 1;
      check("start_ready", 64'(bus.global_ready), 64'd1);
      check("start_enabled", 64'(bus.enabled), 64'd1);
      check("start_value", 64'(bus.start_value), 64'd1);
      check("start_limit", 64'(bus.limit), 64'(lim));
      check("start_dist", 64'(bus.distances), 64'd0);
      check("start_busy", 64'(busy), 64'd1);
      check("start_done", 64'(done), 64'd0);
      check("start_error", 64'(error), 64'd0);
      check("start_steps", 64'(steps), 64'd0);
   endtask

   // One round: k = cycles after the strobe before ready rises, k < 0 = never.
   task automatic do_round(input int n, input int k, input bit use_fixed);
      int                 a;
      int                 lat;
      int                 sol_cnt;
      int                 exp_lat;
      bit                 term;
      bit                 sol;
      bit                 exp_err;
      bit                 fin;
      logic [VW-1:0]      vals   [1:NPOS];
      logic [VW-1:0]      starts [1:NPOS];
      logic [MAXV-1:0]    hash   [1:NPOS];
      logic [NPOS*VW-1:0] exp_marks;
      logic [NPOS-1:0]    rdy;

      a = m_enabled;
      for (int l = 1; l <= NPOS; l++) begin
         vals[l]   = use_fixed ? fixed_vals[l] : VW'($urandom);
         starts[l] = VW'($urandom);
         hash[l]   = MAXV'({$urandom(), $urandom()});
         exp_marks[(l-1)*VW +: VW]             = vals[l];
         bus.cnt_val[(l-1)*VW +: VW]           = vals[l];
         bus.cnt_next_start[(l-1)*VW +: VW]    = starts[l];
         bus.cnt_pd_hash[(l-1)*MAXV +: MAXV]   = hash[l];
         bus.cnt_next_enabled[(l-1)*EW +: EW]  = EW'($urandom);
      end
      bus.cnt_next_enabled[(a-1)*EW +: EW] = EW'(n);
      rdy        = NPOS'($urandom);
      rdy[a-1]   = (k == 0);
      bus.cnt_ready = rdy;

      sol = 1'b0; term = 1'b0; exp_err = 1'b0;
      if (k < 0) begin
         term = 1'b1; exp_err = 1'b1; exp_lat = TIMEOUT + 1;
      end else begin
         exp_lat = (k + 2 > 4) ? k + 2 : 4;
         if (n == 0) begin
            term = 1'b1;
         end else if (n == NPOS + 1) begin
            sol = 1'b1; m_limit = vals[NPOS];
         end else if (n <= NPOS) begin
            m_start_value = starts[a];
            m_enabled     = n;
            m_distances   = '0;
            for (int l = 1; l < n; l++) m_distances = m_distances | hash[l];
         end else begin
            term = 1'b1; exp_err = 1'b1;
         end
      end

      lat = 0; sol_cnt = 0; fin = 1'b0;
      while (!fin && lat < 200) begin
         @(negedge clock);
         lat++;
         if (sol_valid === 1'b1) sol_cnt++;
         if (bus.global_ready === 1'b1 || done === 1'b1) begin
            fin = 1'b1;
         end else begin
            start = (lat == 1);
            if (lat == 1) init_limit = VW'($urandom);
            if (k > 0 && lat == k) bus.cnt_ready[a-1] = 1'b1;
         end
      end
      start = 1'b0;

      check("round_latency", 64'(lat), 64'(exp_lat));
      check("sol_pulses", 64'(sol_cnt), 64'(sol));
      if (term) begin
         check("fin_done", 64'(done), 64'd1);
         check("fin_error", 64'(error), 64'(exp_err));
         check("fin_busy", 64'(busy), 64'd0);
         check("fin_enabled", 64'(bus.enabled), 64'd0);
         check("fin_ready", 64'(bus.global_ready), 64'd0);
         check("fin_steps", 64'(steps), 64'(m_issues));
         check("fin_limit", 64'(bus.limit), 64'(m_limit));
      end else begin
         m_issues++;
         check("rnd_enabled", 64'(bus.enabled), 64'(m_enabled));
         check("rnd_start_value", 64'(bus.start_value), 64'(m_start_value));
         check("rnd_limit", 64'(bus.limit), 64'(m_limit));
         check("rnd_distances", 64'(bus.distances), 64'(m_distances));
         check("rnd_busy", 64'(busy), 64'd1);
         check("rnd_done", 64'(done), 64'd0);
         check("rnd_steps", 64'(steps), 64'(m_issues - 1));
         if (sol) check("sol_marks", 64'(sol_marks), 64'(exp_marks));
      end
      bus.cnt_ready = '0;
   endtask

   initial begin
      int nr;
      int nn;
      reset      = 1'b1;
      start      = 1'b0;
      init_limit = '0;
      bus.cnt_ready        = '0;
      bus.cnt_next_enabled = '0;
      bus.cnt_next_start   = '0;
      bus.cnt_val          = '0;
      bus.cnt_pd_hash      = '0;
      #12;
      check("rst_enabled", 64'(bus.enabled), 64'd0);
      check("rst_ready", 64'(bus.global_ready), 64'd0);
      check("rst_start_value", 64'(bus.start_value), 64'd0);
      check("rst_limit", 64'(bus.limit), 64'd0);
      check("rst_distances", 64'(bus.distances), 64'd0);
      check("rst_sol_valid", 64'(sol_valid), 64'd0);
      check("rst_sol_marks", 64'(sol_marks), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_error", 64'(error), 64'd0);
      check("rst_steps", 64'(steps), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // directed search: minimal round, full ruler 0,1,4,10,12,17, normal finish
      fixed_vals[1] = 6'd1;  fixed_vals[2] = 6'd4;  fixed_vals[3] = 6'd10;
      fixed_vals[4] = 6'd12; fixed_vals[5] = 6'd17;
      start_search(6'd20);
      do_round(2, 0, 1'b0);
      do_round(5, 1, 1'b0);
      do_round(NPOS + 1, 3, 1'b1);
      check("ruler_limit", 64'(bus.limit), 64'd17);
      do_round(NPOS + 1, 0, 1'b0);
      do_round(0, 2, 1'b0);

      // ready never arrives: timeout
      start_search(6'd40);
      do_round(3, 1, 1'b0);
      do_round(1, -1, 1'b0);

      // illegal token value
      start_search(6'd25);
      do_round(4, 2, 1'b0);
      do_round(7, 0, 1'b0);

      // asynchronous reset while waiting at level 3
      start_search(6'd30);
      do_round(3, 0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_enabled", 64'(bus.enabled), 64'd0);
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_ready", 64'(bus.global_ready), 64'd0);
      check("mid_rst_steps", 64'(steps), 64'd0);
      check("mid_rst_sol", 64'(sol_valid), 64'd0);
      @(negedge clock);
      check("mid_rst_sol_held", 64'(sol_valid), 64'd0);
      reset = 1'b0;

      // random searches
      for (int s = 0; s < 6; s++) begin
         start_search(VW'($urandom_range(63, 8)));
         nr = $urandom_range(12, 3);
         for (int r = 0; r < nr; r++) begin
            if (m_enabled == NPOS && $urandom_range(2, 0) == 0) nn = NPOS + 1;
            else nn = $urandom_range(NPOS, 1);
            do_round(nn, $urandom_range(5, 0), 1'b0);
         end
         nn = ($urandom_range(1, 0) == 1) ? 0 : 7;
         do_round(nn, $urandom_range(5, 0), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/ruler_search_sequencer.md
Name: ruler_search_sequencer

Overview:
- Central controller for the chain of mark counters in the Golomb ruler search.
- Owns the single "enabled" level token and the global ready strobe, and steps the active counter once per round.
- Aggregates the pair-distance hashes of all levels above the active one, and detects completed rulers.
- Tightens the length limit after each found ruler, and declares the search finished when the token returns to level 0.

Parameters:
- NPOS, 5: number of variable mark levels (1..NPOS). Mark 0 is fixed at 0.
- VW, 6: bit width of a mark position value.
- MAXV, 63: distance hash width (bits 1..MAXV). Must be ≤ 2^VW-1.
- EW, 3: width of the level token. Must hold 0..NPOS+1.
- TIMEOUT, 64: maximum cycles to wait for the active counter's ready before raising an error.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle pulse; begins a search (ignored unless idle)
- init_limit  in  VW  initial exclusive length bound
- cnt_ready  in  NPOS  per-level ready from counters; bit l-1 is level l
- cnt_next_enabled  in  NPOS*EW  per-level nextEnabled, level 1 in LSBs
- cnt_next_start  in  NPOS*VW  per-level nextStartValue
- cnt_val  in  NPOS*VW  per-level current position
- cnt_pd_hash  in  NPOS*MAXV  per-level pdHash
- enabled  out  EW  level token broadcast to all counters
- global_ready  out  1  step strobe to counters
- start_value  out  VW  startvalue broadcast
- limit  out  VW  current exclusive bound
- distances  out  MAXV  OR of cnt_pd_hash over levels 1..enabled-1
- sol_valid  out  1  one-cycle pulse per ruler found
- sol_marks  out  NPOS*VW  snapshot of cnt_val at the solution
- busy  out  1  search in progress
- done  out  1  search finished; sticky until next start or reset
- error  out  1  timeout occurred; sticky until next start or reset
- steps  out  32  count of issued steps; saturating

Behaviour:
- Reset values (asynchronous reset):
  - state=IDLE; enabled=0; global_ready=0; start_value=0; limit=0; distances=0.
  - sol_valid=0; sol_marks=0; busy=0; done=0; error=0; steps=0.
  - Reset mid-search aborts immediately. No solution pulse is emitted.
- States: IDLE, ISSUE, WAIT, EVAL, FIN.
- IDLE:
  - start=1 loads limit=init_limit, enabled=1, start_value=1, distances=0, steps=0.
  - Clears done and error, sets busy=1, and moves to ISSUE.
- ISSUE (1 cycle):
  - global_ready=1 for exactly this cycle.
  - steps increments, saturating at 2^32-1.
  - Moves to WAIT with the wait counter cleared.
- WAIT:
  - global_ready=0.
  - Move to EVAL in the first cycle where all of these hold: at least 2 cycles since ISSUE; cnt_ready[enabled-1]=1; the active counter's cnt_next_enabled differs from the token or cnt_val has changed since ISSUE, or at least 2 cycles have elapsed. The 2-cycle minimum always applies.
  - If the wait counter reaches TIMEOUT first: error=1, go to FIN.
- EVAL (1 cycle): let a=enabled and n=cnt_next_enabled[a].
  - n==0: go to FIN.
  - n==NPOS+1 (full ruler):
    - sol_valid=1 for this cycle; sol_marks=cnt_val.
    - limit=cnt_val[NPOS], so subsequent rulers must be strictly shorter.
    - enabled stays NPOS; go to ISSUE.
  - 1≤n≤NPOS:
    - enabled=n; start_value=cnt_next_start[a].
    - distances = OR of cnt_pd_hash[l] for 1≤l<n, computed from this cycle's inputs.
    - Go to ISSUE.
  - n>NPOS+1 (illegal): error=1, go to FIN.
- FIN:
  - enabled=0, busy=0, done=1, global_ready=0.
  - Go to IDLE the next cycle. done and error stay asserted.
- start asserted in any state other than IDLE is ignored.
- Round latency: minimum 4 cycles (ISSUE, WAIT ×2, EVAL).
- Outputs change only on posedge clock. sol_valid is never asserted in the same cycle as done.

Test Plan:
- Reset during WAIT with enabled=3 → next cycle enabled=0, busy=0, global_ready=0, steps=0; no sol_valid.
- start, init_limit=20; level-1 model answers nextEnabled=2, nextStart=2 → global_ready high for exactly 1 cycle; EVAL occurs 3 cycles after ISSUE; then enabled=2, start_value=2, distances=cnt_pd_hash[1].
- NPOS=3, init_limit=10; behavioural counters yield 0,1,4,6 → sol_valid pulse with sol_marks={6,4,1} and limit=6; later solutions only with length<6.
- Level-1 model returns nextEnabled=0 → done=1 and busy=0 within 2 cycles; enabled=0; steps equals the issued count.
- cnt_ready held low after ISSUE → error=1 and done=1 after TIMEOUT=64 wait cycles.
- start pulsed while busy, and illegal nextEnabled=7 (NPOS=5) → start ignored; the illegal value sets error=1 and leads to FIN.
